// File: rtl/cp_pingpong_sched.sv
// cp_pingpong_sched: ping-pong bank sequencer for TX cyclic-prefix insertion.
// Writes IFFT symbols into alternating banks and reads each back as CP tail followed by the full body.
module cp_pingpong_sched #(
    parameter int NFFT = 64,
    parameter int LCP  = 16,
    parameter int AW   = 6
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          FLUSH_I,
    input  logic          IN_VLD_I,
    output logic          IN_RDY_O,
    output logic          WR_EN_O,
    output logic          WR_BANK_O,
    output logic [AW-1:0] WR_ADDR_O,
    input  logic          OUT_RDY_I,
    output logic          RD_EN_O,
    output logic          RD_BANK_O,
    output logic [AW-1:0] RD_ADDR_O,
    output logic          OUT_VLD_O,
    output logic          OUT_SOS_O,
    output logic          OUT_EOS_O,
    output logic [1:0]    BANK_FULL_O,
    output logic [15:0]   SYM_CNT_O
);
    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
    state_t state_q, state_d;
    logic run_q, run_d, wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic vld_q, vld_d, sos_q, sos_d, eos_q, eos_d;
    logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0] full_q, full_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic cp_last, body_last;

    assign WR_BANK_O   = wr_bank_q;
    assign WR_ADDR_O   = wcnt_q;
    assign RD_BANK_O   = rd_bank_q;
    assign OUT_VLD_O   = vld_q;
    assign OUT_SOS_O   = sos_q;
    assign OUT_EOS_O   = eos_q;
    assign BANK_FULL_O = full_q;
    assign SYM_CNT_O   = sym_cnt_q;

    // run_q keeps IN_RDY_O low until the first edge after reset or flush.
    always_comb begin
        IN_RDY_O  = run_q & ~full_q[wr_bank_q] & ~FLUSH_I;
        WR_EN_O   = IN_VLD_I & IN_RDY_O;
        RD_EN_O   = (state_q != IDLE) & OUT_RDY_I & ~FLUSH_I;
        cp_last   = rcnt_q == AW'(LCP - 1);
        body_last = rcnt_q == AW'(NFFT - 1);
        RD_ADDR_O = state_q == CP ? AW'(NFFT - LCP) + rcnt_q : state_q == BODY ? rcnt_q : '0;
        run_d     = 1'b1;
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        full_d    = full_q;
        sym_cnt_d = sym_cnt_q;
        vld_d     = RD_EN_O;
        sos_d     = RD_EN_O & (state_q == CP) & (rcnt_q == '0);
        eos_d     = RD_EN_O & (state_q == BODY) & body_last;
        if (WR_EN_O) begin
            wcnt_d = wcnt_q + AW'(1);
            if (wcnt_q == AW'(NFFT - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        case (state_q)
            IDLE: if (full_q[rd_bank_q]) state_d = CP;
            CP: if (RD_EN_O) begin
                rcnt_d = cp_last ? '0 : rcnt_q + AW'(1);
                if (cp_last) state_d = BODY;
            end
            BODY: if (RD_EN_O) begin
                rcnt_d = body_last ? '0 : rcnt_q + AW'(1);
                if (body_last) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    sym_cnt_d         = sym_cnt_q + 16'd1;
                    state_d           = full_q[~rd_bank_q] ? CP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (FLUSH_I) begin
            run_d     = 1'b0;
            state_d   = IDLE;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wcnt_d    = '0;
            rcnt_d    = '0;
            full_d    = '0;
            sym_cnt_d = '0;
            vld_d     = 1'b0;
            sos_d     = 1'b0;
            eos_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            run_q     <= 1'b0;
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            full_q    <= '0;
            sym_cnt_q <= '0;
            vld_q     <= 1'b0;
            sos_q     <= 1'b0;
            eos_q     <= 1'b0;
        end else begin
            run_q     <= run_d;
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            full_q    <= full_d;
            sym_cnt_q <= sym_cnt_d;
            vld_q     <= vld_d;
            sos_q     <= sos_d;
            eos_q     <= eos_d;
        end
    end
endmodule

// File: tb/tb_cp_pingpong_sched.sv
// tb_cp_pingpong_sched: randomized and directed checks of the CP ping-pong scheduler.
// The model tracks symbols written/read and each symbol's expected 80-read address pattern.
module tb_cp_pingpong_sched;
    localparam int NFFT = 64;
    localparam int LCP  = 16;
    localparam int AW   = 6;
    localparam int SLEN = NFFT + LCP;

    logic clk = 1'b0;
    logic rst, flush, in_vld, out_rdy;
    logic in_rdy, wr_en, wr_bank, rd_en, rd_bank, out_vld, out_sos, out_eos;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0] bank_full;
    logic [15:0] sym_cnt;

    int total = 0, bad = 0;
    int wcount, wsyms, rsyms, rpos;
    bit p_vld, p_sos, p_eos, exp_rdy, mon_en = 1'b0;

    cp_pingpong_sched #(.NFFT(NFFT), .LCP(LCP), .AW(AW)) dut (
        .CLK_I(clk), .RST_I(rst), .FLUSH_I(flush), .IN_VLD_I(in_vld), .IN_RDY_O(in_rdy),
        .WR_EN_O(wr_en), .WR_BANK_O(wr_bank), .WR_ADDR_O(wr_addr), .OUT_RDY_I(out_rdy),
        .RD_EN_O(rd_en), .RD_BANK_O(rd_bank), .RD_ADDR_O(rd_addr), .OUT_VLD_O(out_vld),
        .OUT_SOS_O(out_sos), .OUT_EOS_O(out_eos), .BANK_FULL_O(bank_full), .SYM_CNT_O(sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        wcount = 0; wsyms = 0; rsyms = 0; rpos = 0;
        p_vld = 0; p_sos = 0; p_eos = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {in_rdy, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
                  out_vld, out_sos, out_eos, bank_full, sym_cnt}, 64'd0);
    endtask

    // A bank holds an unread symbol from its last write until its last body read.
    always @(negedge clk) if (mon_en) begin
        exp_rdy = (wsyms - rsyms) < 2;
        chk("out_vld", out_vld, p_vld);
        chk("out_sos", out_sos, p_sos);
        chk("out_eos", out_eos, p_eos);
        chk("sym_cnt", sym_cnt, rsyms % 65536);
        chk("in_rdy", in_rdy, exp_rdy);
        chk("wr_en", wr_en, in_vld & exp_rdy);
        if (!out_rdy) chk("rd_hold", rd_en, 0);
        p_vld = rd_en; p_sos = 0; p_eos = 0;
        if (rd_en) begin
            chk("rd_ready", rsyms < wsyms, 1);
            chk("rd_bank", rd_bank, rsyms % 2);
            chk("rd_addr", rd_addr, rpos < LCP ? NFFT - LCP + rpos : rpos - LCP);
            if (wr_en) chk("bank_clash", rd_bank != wr_bank, 1);
            p_sos = rpos == 0;
            p_eos = rpos == SLEN - 1;
            rpos++;
            if (rpos == SLEN) begin rpos = 0; rsyms++; end
        end
        if (in_vld && exp_rdy) begin
            chk("wr_addr", wr_addr, wcount % NFFT);
            chk("wr_bank", wr_bank, (wcount / NFFT) % 2);
            wcount++;
            if (wcount % NFFT == 0) wsyms++;
        end
    end

    task automatic do_flush();
        mon_en = 0; flush = 1; in_vld = 0;
        @(negedge clk);
        chk("flush_gate", {in_rdy, rd_en}, 0);
        step();
        flush = 0;
        @(negedge clk);
        chk_zero("flush_zero");
        reset_model();
        step();
        mon_en = 1;
    endtask

    task automatic feed(input int n, input bit rnd, input int budget);
        int hs = 0, c = 0;
        while (hs < n && c < budget) begin
            in_vld = rnd ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            if (in_vld && in_rdy) hs++;
            step();
            c++;
        end
        in_vld = 0;
        chk("feed_count", hs, n);
    endtask

    task automatic wait_syms(input int n, input int budget);
        int c = 0;
        while (rsyms < n && c < budget) begin @(negedge clk); c++; end
        chk("wait_syms", rsyms, n);
        @(negedge clk);
        chk("sym_cnt_done", sym_cnt, n);
        step();
    endtask

    initial begin
        int n, c, run;
        rst = 1; flush = 0; in_vld = 0; out_rdy = 1;
        repeat (2) @(negedge clk);
        chk_zero("reset_zero");
        step();
        rst = 0;
        @(negedge clk);
        chk("rdy_after_rst", in_rdy, 0);
        step();
        reset_model();
        mon_en = 1;

        // single symbol, latency of first output
        feed(NFFT, 0, 200);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_vld && n < 20);
        chk("latency", n, 3);
        step();
        wait_syms(1, 200);

        // four back-to-back symbols, output must be gapless
        do_flush();
        fork
            feed(4 * NFFT, 0, 600);
            begin
                c = 0;
                while (!out_vld && c < 300) begin @(negedge clk); c++; end
                run = 0;
                while (out_vld && run < 400) begin run++; @(negedge clk); end
                chk("gapless_run", run, 4 * SLEN);
            end
        join
        wait_syms(4, 400);

        // downstream stall with both banks filling
        do_flush();
        fork
            feed(2 * NFFT, 0, 400);
            begin
                c = 0;
                while (!out_vld && c < 200) begin @(negedge clk); c++; end
                step();
                out_rdy = 0;
                repeat (150) step();
                @(negedge clk);
                chk("stall_full", bank_full, 2'b11);
                chk("stall_rdy", in_rdy, 0);
                repeat (50) step();
                out_rdy = 1;
            end
        join
        wait_syms(2, 400);

        // random handshakes on both sides
        do_flush();
        fork
            feed(20 * NFFT, 1, 8000);
            begin
                c = 0;
                while (rsyms < 20 && c < 12000) begin out_rdy = 1'($urandom % 2); step(); c++; end
                out_rdy = 1;
            end
        join
        wait_syms(20, 300);

        // flush in the body of the second symbol, then a fresh symbol
        do_flush();
        feed(2 * NFFT, 0, 400);
        c = 0;
        while (!(rsyms == 1 && rpos >= LCP + 30) && c < 400) begin @(negedge clk); c++; end
        chk("reach_sym2_body", rsyms, 1);
        step();
        do_flush();
        feed(NFFT, 0, 200);
        wait_syms(1, 200);

        // asynchronous reset in the middle of a write
        in_vld = 1;
        repeat (30) step();
        mon_en = 0;
        #3 rst = 1;
        #1 chk_zero("async_rst_zero");
        repeat (2) step();
        rst = 0;
        step();
        reset_model();
        mon_en = 1;
        @(negedge clk);
        chk("restart_wr", {wr_en, wr_bank, wr_addr}, {1'b1, 1'b0, 6'd0});
        step();
        in_vld = 0;
        feed(NFFT - 1, 0, 200);
        wait_syms(1, 200);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp_pingpong_sched.md
Name: cp_pingpong_sched

Overview:
- Controller for the TX cyclic-prefix insertion datapath. Sits between the IFFT output stream and a two-bank symbol RAM (bank = NFFT words per I/Q rail).
- Sequences writes of each IFFT symbol into alternating banks.
- Sequences reads of LCP+NFFT words per symbol: CP tail first, then full body. Outputs are gapless back-to-back when banks are ready.
- Generates RAM address/enable, bank select and symbol framing strobes. The sample data path itself is external.

Parameters:
NFFT, 64, samples per OFDM symbol (power of 2)
LCP, 16, cyclic prefix length; 1 <= LCP <= NFFT
AW, 6, address width = log2(NFFT)

Ports:
CLK_I  in  1  clock (single domain)
RST_I  in  1  asynchronous, active-high reset
FLUSH_I  in  1  synchronous abort; returns the block to reset state
IN_VLD_I  in  1  IFFT sample valid
IN_RDY_O  out  1  block can accept a sample
WR_EN_O  out  1  RAM write strobe
WR_BANK_O  out  1  bank being written
WR_ADDR_O  out  AW  write address
OUT_RDY_I  in  1  downstream can accept a sample
RD_EN_O  out  1  RAM read strobe (1-cycle RAM latency)
RD_BANK_O  out  1  bank being read
RD_ADDR_O  out  AW  read address
OUT_VLD_O  out  1  RAM read data valid this cycle
OUT_SOS_O  out  1  first CP sample of a symbol, qualified by OUT_VLD_O
OUT_EOS_O  out  1  last body sample of a symbol, qualified by OUT_VLD_O
BANK_FULL_O  out  2  per-bank full flags
SYM_CNT_O  out  16  completed output symbols, wraps at 2^16

Behaviour:
- Reset (RST_I or FLUSH_I): all outputs 0; wr_bank=rd_bank=0; wcnt=rcnt=0; state IDLE.
  - IN_RDY_O rises in the first cycle after reset is released.
  - FLUSH_I overrides any same-cycle handshake, write or read.
- Write side:
  - IN_RDY_O = ~BANK_FULL_O[wr_bank] & ~FLUSH_I.
  - On IN_VLD_I & IN_RDY_O: WR_EN_O=1, WR_ADDR_O=wcnt, WR_BANK_O=wr_bank (combinational, same cycle); wcnt increments.
  - When wcnt=NFFT-1 is accepted: BANK_FULL_O[wr_bank] sets at the next edge, wr_bank toggles, wcnt returns to 0.
- Read FSM: IDLE, CP, BODY.
  - IDLE -> CP when BANK_FULL_O[rd_bank]=1; rcnt=0.
  - CP: RD_ADDR_O = NFFT-LCP+rcnt. After LCP issued reads -> BODY, rcnt=0.
  - BODY: RD_ADDR_O = rcnt. After NFFT issued reads: clear BANK_FULL_O[rd_bank], toggle rd_bank, increment SYM_CNT_O.
    - Next state CP if the other bank is already full (no idle cycle), else IDLE.
  - RD_EN_O = (state != IDLE) & OUT_RDY_I. rcnt advances only on RD_EN_O.
  - OUT_VLD_O, OUT_SOS_O and OUT_EOS_O are RD_EN_O, first-CP-read and last-BODY-read delayed one cycle.
  - Downstream must absorb one sample after deasserting OUT_RDY_I (one-entry skid).
- Latency: last input accepted at cycle t -> full flag visible at t+1 -> CP at t+2 -> first OUT_VLD_O at t+3 (OUT_RDY_I held high).
- Throughput: one output per cycle; LCP+NFFT output cycles per symbol. Input stalls (IN_RDY_O=0) only when both banks are full.
- Simultaneous events: a write-side full-set and a read-side full-clear in the same cycle apply to different banks and both take effect. Read never targets the write bank while it is filling.
- Full-flag updates for the same bank in one cycle cannot occur.

Test Plan:
- Single symbol, OUT_RDY_I=1: 64 inputs with data = address. Output 80 samples with RD_ADDR 48..63 then 0..63; SOS on sample 1, EOS on sample 80; first OUT_VLD 3 cycles after last input; SYM_CNT=1.
- Continuous input, 4 symbols: OUT_VLD stays high for 320 consecutive cycles with no gap; RD_BANK alternates 0,1,0,1; SYM_CNT=4.
- Downstream stall: OUT_RDY_I=0 for 200 cycles after the first symbol begins. IN_RDY_O drops after 128 inputs with BANK_FULL=2'b11; on release, output resumes at the correct address with no skipped or repeated read.
- Random OUT_RDY_I (50%) plus random IN_VLD_I, 20 symbols. Scoreboard checks every output address sequence (CP tail then body) and that reads never hit a bank being written.
- FLUSH_I asserted mid-BODY of symbol 2: next cycle all outputs 0, BANK_FULL=0, SYM_CNT=0; a fresh symbol then outputs normally.
- RST_I asserted asynchronously mid-write: outputs clear immediately without waiting for a clock edge; wcnt restarts at address 0 on bank 0.
